ball_engine: RTL and testbench
==============================

BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- SCREEN_W, 640: playfield width in pixels.
- SCREEN_H, 480: playfield height in pixels.
- POS_W, 10: width of every position bus.
- BALL_SIZE, 10: ball side length.
- PADDLE_HALF_H, 50: half paddle height.
- PADDLE_W, 10: paddle width.
- PADDLE_X_OFF, 50: distance from own back wall to the paddle's back face.
- PADDLE_VEL, 2: paddle pixels per frame.
- VEL_W, 4: velocity width.
- SERVE_VX, 3: serve x-speed.
- SERVE_VY, 2: serve y-velocity, signed.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1: single clock; all state is on its rising edge.
- reset_L, in, 1: asynchronous, active-low reset.
- update_screen, in, 1: one-cycle frame tick.
- is_left_player, in, 1: 1 = own paddle on left; static after reset.
- joystick_up, in, 1: move paddle up.
- joystick_down, in, 1: move paddle down.
- arcade_button_pressed, in, 1: launch a held serve.
- serve_start, in, 1: pulse; this side takes the serve.
- ball_in_valid, in, 1: incoming-ball handshake valid.
- ball_in_ready, out, 1: incoming-ball handshake ready.
- ball_in_y, in, POS_W: incoming ball_top.
- ball_in_vx, in, VEL_W: unsigned speed.
- ball_in_vy, in, VEL_W: signed, positive = down.
- ball_out_valid, out, 1: outgoing-ball handshake valid.
- ball_out_ready, in, 1: outgoing-ball handshake ready.
- ball_out_y, out, POS_W: outgoing ball_top.
- ball_out_vx, out, VEL_W: outgoing speed.
- ball_out_vy, out, VEL_W: outgoing y-velocity.
- miss_valid, out, 1: miss-report handshake valid.
- miss_ready, in, 1: miss-report handshake ready.
- ball_left, out, POS_W: ball left column.
- ball_top, out, POS_W: ball top row.
- ball_visible, out, 1: ball is on this side.
- paddleX, out, POS_W: paddle reference column.
- paddleY, out, POS_W: paddle centre row.
- opp_score, out, 5: opponent point counter.

Function
REQ-003 Five states SHALL exist: IDLE, SERVE, PLAY, SEND, MISS.
REQ-004 The paddle front column F SHALL be PADDLE_X_OFF+PADDLE_W for the left player and SCREEN_W-PADDLE_X_OFF-PADDLE_W for the right player; paddleX SHALL equal F.
REQ-005 On update_screen, in any state, with exactly one joystick asserted, paddleY SHALL move by PADDLE_VEL (up = decrement), clamped to [PADDLE_HALF_H, SCREEN_H-1-PADDLE_HALF_H].
- Both joysticks asserted or neither: no movement.
REQ-006 IDLE:
- ball_in_ready=1 and ball_visible=0.
- ball_in handshake: go to PLAY; ball_top=ball_in_y; ball enters at the far edge (left player: ball_left=SCREEN_W-BALL_SIZE; right player: 0), moving toward own paddle; vx=ball_in_vx, vy=ball_in_vy.
- serve_start alone: go to SERVE.
- ball_in handshake and serve_start in the same cycle: the handshake wins and serve_start is dropped.
REQ-007 SERVE:
- Every cycle: ball_top=paddleY-BALL_SIZE/2; ball abuts the paddle front on the opponent side.
- arcade_button_pressed: go to PLAY with vx=SERVE_VX, vy=SERVE_VY, heading toward the opponent.
REQ-008 PLAY: position SHALL update only on update_screen cycles, x by ±vx and y by vy (signed add). The checks below are evaluated on the candidate position in this priority order:
- (a) Own back wall reached (left player: x<=vx before the step; right player: right edge >=SCREEN_W): go to MISS.
- (b) Ball crosses F moving toward own side while its rows overlap [paddleY-PADDLE_HALF_H, paddleY+PADDLE_HALF_H]: clamp to F and reverse x direction.
- (c) Far wall reached: go to SEND.
- (d) Top <=0 or bottom >=SCREEN_H-1: clamp inside the playfield and negate vy.
REQ-009 Arithmetic SHALL be computed at POS_W+1 bits so no wrap-around occurs.
- Negating vy at the most negative value (-8 for VEL_W=4) SHALL saturate to +7.
REQ-010 SEND:
- ball_out_valid=1 with y/vx/vy frozen at the exit frame's values.
- Hold until ball_out_ready, then go to IDLE with ball_visible=0.
REQ-011 MISS:
- miss_valid=1; opp_score increments on the entry edge, saturating at 31.
- Hold until miss_ready, then go to IDLE.
REQ-012 In SEND and MISS, update_screen SHALL NOT move the ball.
- Paddle movement per REQ-005 continues.
REQ-013 Every handshake SHALL complete on a cycle where valid&&ready; valid SHALL NOT drop before completion.

Reset
REQ-014 reset_L low SHALL immediately force the following, including mid-handshake:
- State IDLE.
- paddleY=SCREEN_H/2.
- ball_left=0, ball_top=0, vx=0, vy=0.
- ball_visible=0, ball_out_valid=0, miss_valid=0, opp_score=0.
- ball_in_ready SHALL go to 1 on the first cycle after release.

Verification
REQ-015 Left player, IDLE; handshake with ball_in_y=100, vx=3, vy=-2 -> PLAY; ball_left=630, ball_top=100; after one tick ball_left=627, ball_top=98.
REQ-016 Ball moving left reaches F=60 with paddleY=240, ball_top=235 -> ball_left=60, direction flips, no MISS.
REQ-017 Same approach with ball_top=400, paddleY=240 -> MISS; miss_valid held for 5 cycles with miss_ready=0; opp_score=1 after the handshake.
REQ-018 Ball exits at the far wall with ball_out_ready=0 for 3 frames -> ball_out_* stable and ball not moving; ready=1 -> IDLE, ball_visible=0.
REQ-019 vy=-8 at the top wall -> vy=+7, ball_top clamped >=0; both joysticks held for 10 frames -> paddleY unchanged.
REQ-020 reset_L asserted during SEND -> ball_out_valid=0 in the same cycle; paddleY=240 after release.

Source files
------------

// File: rtl/ball_engine.sv
// One side of a two-screen Pong: paddle, serve, ball flight with wall and paddle
// bounces, and valid/ready hand-off of the ball to and from the opposite side.
module ball_engine #(
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int POS_W         = 10,
  parameter int BALL_SIZE     = 10,
  parameter int PADDLE_HALF_H = 50,
  parameter int PADDLE_W      = 10,
  parameter int PADDLE_X_OFF  = 50,
  parameter int PADDLE_VEL    = 2,
  parameter int VEL_W         = 4,
  parameter int SERVE_VX      = 3,
  parameter int SERVE_VY      = 2
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             update_screen,
  input  logic             is_left_player,
  input  logic             joystick_up,
  input  logic             joystick_down,
  input  logic             arcade_button_pressed,
  input  logic             serve_start,
  input  logic             ball_in_valid,
  output logic             ball_in_ready,
  input  logic [POS_W-1:0] ball_in_y,
  input  logic [VEL_W-1:0] ball_in_vx,
  input  logic [VEL_W-1:0] ball_in_vy,
  output logic             ball_out_valid,
  input  logic             ball_out_ready,
  output logic [POS_W-1:0] ball_out_y,
  output logic [VEL_W-1:0] ball_out_vx,
  output logic [VEL_W-1:0] ball_out_vy,
  output logic             miss_valid,
  input  logic             miss_ready,
  output logic [POS_W-1:0] ball_left,
  output logic [POS_W-1:0] ball_top,
  output logic             ball_visible,
  output logic [POS_W-1:0] paddleX,
  output logic [POS_W-1:0] paddleY,
  output logic [4:0]       opp_score
);

  localparam int XW = POS_W + 1;
  typedef logic signed [XW-1:0] coord_t;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    SEND  = 3'd3,
    MISS  = 3'd4
  } state_t;

  // Signed one-bit-wider constants for comparisons; POS_W-wide ones for storage.
  localparam coord_t C_ZERO    = coord_t'(0);
  localparam coord_t C_SW      = coord_t'(SCREEN_W);
  localparam coord_t C_BS      = coord_t'(BALL_SIZE);
  localparam coord_t C_BS_M1   = coord_t'(BALL_SIZE - 1);
  localparam coord_t C_SH_M1   = coord_t'(SCREEN_H - 1);
  localparam coord_t C_PH      = coord_t'(PADDLE_HALF_H);
  localparam coord_t C_PVEL    = coord_t'(PADDLE_VEL);
  localparam coord_t C_PMIN    = coord_t'(PADDLE_HALF_H);
  localparam coord_t C_PMAX    = coord_t'(SCREEN_H - 1 - PADDLE_HALF_H);
  localparam coord_t C_FRONT_L = coord_t'(PADDLE_X_OFF + PADDLE_W);
  localparam coord_t C_FRONT_R = coord_t'(SCREEN_W - PADDLE_X_OFF - PADDLE_W);

  localparam logic [POS_W-1:0] P_FRONT_L = POS_W'(PADDLE_X_OFF + PADDLE_W);
  localparam logic [POS_W-1:0] P_FRONT_R = POS_W'(SCREEN_W - PADDLE_X_OFF - PADDLE_W);
  localparam logic [POS_W-1:0] P_ABUT_R  = POS_W'(SCREEN_W - PADDLE_X_OFF - PADDLE_W - BALL_SIZE);
  localparam logic [POS_W-1:0] P_FAR_L   = POS_W'(SCREEN_W - BALL_SIZE);
  localparam logic [POS_W-1:0] P_BOT     = POS_W'(SCREEN_H - BALL_SIZE);
  localparam logic [POS_W-1:0] P_RESET_Y = POS_W'(SCREEN_H / 2);
  localparam logic [POS_W-1:0] P_PMIN    = POS_W'(PADDLE_HALF_H);
  localparam logic [POS_W-1:0] P_PMAX    = POS_W'(SCREEN_H - 1 - PADDLE_HALF_H);
  localparam logic [POS_W-1:0] P_HALF_BS = POS_W'(BALL_SIZE / 2);

  function automatic logic [4:0] sat_inc(input logic [4:0] s);
    return (s == 5'd31) ? 5'd31 : s + 5'd1;
  endfunction

  // Negating the most negative velocity would wrap back to itself, so pin it.
  function automatic logic signed [VEL_W-1:0] neg_sat(input logic signed [VEL_W-1:0] v);
    logic signed [VEL_W-1:0] most_neg;
    most_neg = {1'b1, {(VEL_W-1){1'b0}}};
    return (v == most_neg) ? {1'b0, {(VEL_W-1){1'b1}}} : -v;
  endfunction

  state_t                  state_r, state_nx;
  logic [POS_W-1:0]        paddle_y_r, paddle_y_nx;
  logic [POS_W-1:0]        ball_x_r, ball_x_nx, ball_y_r, ball_y_nx;
  logic [VEL_W-1:0]        vx_r, vx_nx;
  logic signed [VEL_W-1:0] vy_r, vy_nx;
  logic                    dir_r, dir_nx;  // 1 = moving toward larger x
  logic [4:0]              score_r, score_nx;
  logic                    in_ready_r, visible_r, out_valid_r, miss_valid_r;

  coord_t bx, by, py, vx_ext, vy_ext, cand_x, cand_y, front, p_up, p_dn;
  logic toward_own, hit_own_wall, rows_overlap, cross_front, far_wall, top_hit, bot_hit;
  logic [POS_W-1:0]        abut_x, far_x, serve_y, y_bounced;
  logic signed [VEL_W-1:0] vy_bounced;

  assign bx     = {1'b0, ball_x_r};
  assign by     = {1'b0, ball_y_r};
  assign py     = {1'b0, paddle_y_r};
  assign vx_ext = {{(XW-VEL_W){1'b0}}, vx_r};
  assign vy_ext = {{(XW-VEL_W){vy_r[VEL_W-1]}}, vy_r};
  assign cand_x = dir_r ? (bx + vx_ext) : (bx - vx_ext);
  assign cand_y = by + vy_ext;
  assign front  = is_left_player ? C_FRONT_L : C_FRONT_R;
  assign p_up   = py - C_PVEL;
  assign p_dn   = py + C_PVEL;

  assign abut_x  = is_left_player ? P_FRONT_L : P_ABUT_R;
  assign far_x   = is_left_player ? P_FAR_L : {POS_W{1'b0}};
  assign serve_y = paddle_y_r - P_HALF_BS;

  assign toward_own   = is_left_player ? ~dir_r : dir_r;
  assign hit_own_wall = toward_own &&
                        (is_left_player ? (bx <= vx_ext) : (cand_x + C_BS >= C_SW));
  assign rows_overlap = (cand_y <= py + C_PH) && (cand_y + C_BS_M1 >= py - C_PH);
  assign cross_front  = toward_own && rows_overlap &&
                        (is_left_player ? ((bx >= front) && (cand_x <= front))
                                        : ((bx + C_BS <= front) && (cand_x + C_BS >= front)));
  assign far_wall     = !toward_own &&
                        (is_left_player ? (cand_x + C_BS >= C_SW) : (cand_x <= C_ZERO));
  assign top_hit      = (cand_y <= C_ZERO);
  assign bot_hit      = (cand_y + C_BS_M1 >= C_SH_M1);
  assign y_bounced    = top_hit ? {POS_W{1'b0}} : (bot_hit ? P_BOT : cand_y[POS_W-1:0]);
  assign vy_bounced   = (top_hit || bot_hit) ? neg_sat(vy_r) : vy_r;

  // Paddle follows a single joystick once per frame, clamped to the playfield.
  always_comb begin
    paddle_y_nx = paddle_y_r;
    if (update_screen && (joystick_up != joystick_down)) begin
      if (joystick_up) begin
        if (p_up < C_PMIN) paddle_y_nx = P_PMIN;
        else               paddle_y_nx = p_up[POS_W-1:0];
      end else begin
        if (p_dn > C_PMAX) paddle_y_nx = P_PMAX;
        else               paddle_y_nx = p_dn[POS_W-1:0];
      end
    end else begin
      paddle_y_nx = paddle_y_r;
    end
  end

  // Ball state machine: next state and next ball position/velocity.
  always_comb begin
    state_nx  = state_r;
    ball_x_nx = ball_x_r;
    ball_y_nx = ball_y_r;
    vx_nx     = vx_r;
    vy_nx     = vy_r;
    dir_nx    = dir_r;
    score_nx  = score_r;
    case (state_r)
      IDLE: begin
        if (ball_in_valid && in_ready_r) begin
          state_nx  = PLAY;
          ball_x_nx = far_x;
          ball_y_nx = ball_in_y;
          vx_nx     = ball_in_vx;
          vy_nx     = ball_in_vy;
          dir_nx    = ~is_left_player;
        end else if (serve_start) begin
          state_nx  = SERVE;
          ball_x_nx = abut_x;
          ball_y_nx = serve_y;
        end else begin
          state_nx = IDLE;
        end
      end
      SERVE: begin
        ball_x_nx = abut_x;
        ball_y_nx = serve_y;
        if (arcade_button_pressed) begin
          state_nx = PLAY;
          vx_nx    = VEL_W'(SERVE_VX);
          vy_nx    = VEL_W'(SERVE_VY);
          dir_nx   = is_left_player;
        end else begin
          state_nx = SERVE;
        end
      end
      PLAY: begin
        if (!update_screen) begin
          state_nx = PLAY;
        end else if (hit_own_wall) begin
          state_nx = MISS;
          score_nx = sat_inc(score_r);
        end else begin
          ball_y_nx = y_bounced;
          vy_nx     = vy_bounced;
          if (cross_front) begin
            ball_x_nx = abut_x;
            dir_nx    = ~dir_r;
          end else if (far_wall) begin
            ball_x_nx = far_x;
            state_nx  = SEND;
          end else begin
            ball_x_nx = cand_x[POS_W-1:0];
          end
        end
      end
      SEND: begin
        if (out_valid_r && ball_out_ready) state_nx = IDLE;
        else                               state_nx = SEND;
      end
      MISS: begin
        if (miss_valid_r && miss_ready) state_nx = IDLE;
        else                            state_nx = MISS;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered handshake/visibility flags.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_r      <= IDLE;
      paddle_y_r   <= P_RESET_Y;
      ball_x_r     <= {POS_W{1'b0}};
      ball_y_r     <= {POS_W{1'b0}};
      vx_r         <= {VEL_W{1'b0}};
      vy_r         <= {VEL_W{1'b0}};
      dir_r        <= 1'b0;
      score_r      <= 5'd0;
      in_ready_r   <= 1'b0;
      visible_r    <= 1'b0;
      out_valid_r  <= 1'b0;
      miss_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nx;
      paddle_y_r   <= paddle_y_nx;
      ball_x_r     <= ball_x_nx;
      ball_y_r     <= ball_y_nx;
      vx_r         <= vx_nx;
      vy_r         <= vy_nx;
      dir_r        <= dir_nx;
      score_r      <= score_nx;
      in_ready_r   <= (state_nx == IDLE);
      visible_r    <= (state_nx != IDLE);
      out_valid_r  <= (state_nx == SEND);
      miss_valid_r <= (state_nx == MISS);
    end
  end

  assign ball_in_ready  = in_ready_r;
  assign ball_visible   = visible_r;
  assign ball_out_valid = out_valid_r;
  assign miss_valid     = miss_valid_r;
  assign ball_left      = ball_x_r;
  assign ball_top       = ball_y_r;
  assign ball_out_y     = ball_y_r;
  assign ball_out_vx    = vx_r;
  assign ball_out_vy    = vy_r;
  assign paddleX        = is_left_player ? P_FRONT_L : P_FRONT_R;
  assign paddleY        = paddle_y_r;
  assign opp_score      = score_r;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: one task per scenario, inline checks against
// hand-computed positions, scores and handshake flags.
module tb_ball_engine;

  logic       clock = 1'b0;
  logic       reset_L = 1'b1;
  logic       update_screen = 1'b0;
  logic       is_left_player = 1'b1;
  logic       joystick_up = 1'b0;
  logic       joystick_down = 1'b0;
  logic       arcade_button_pressed = 1'b0;
  logic       serve_start = 1'b0;
  logic       ball_in_valid = 1'b0;
  logic       ball_in_ready;
  logic [9:0] ball_in_y = 10'd0;
  logic [3:0] ball_in_vx = 4'd0;
  logic [3:0] ball_in_vy = 4'd0;
  logic       ball_out_valid;
  logic       ball_out_ready = 1'b0;
  logic [9:0] ball_out_y;
  logic [3:0] ball_out_vx;
  logic [3:0] ball_out_vy;
  logic       miss_valid;
  logic       miss_ready = 1'b0;
  logic [9:0] ball_left;
  logic [9:0] ball_top;
  logic       ball_visible;
  logic [9:0] paddleX;
  logic [9:0] paddleY;
  logic [4:0] opp_score;

  int pass_cnt = 0;
  int total_cnt = 0;

  ball_engine dut (
    .clock(clock), .reset_L(reset_L), .update_screen(update_screen),
    .is_left_player(is_left_player), .joystick_up(joystick_up),
    .joystick_down(joystick_down), .arcade_button_pressed(arcade_button_pressed),
    .serve_start(serve_start), .ball_in_valid(ball_in_valid),
    .ball_in_ready(ball_in_ready), .ball_in_y(ball_in_y), .ball_in_vx(ball_in_vx),
    .ball_in_vy(ball_in_vy), .ball_out_valid(ball_out_valid),
    .ball_out_ready(ball_out_ready), .ball_out_y(ball_out_y),
    .ball_out_vx(ball_out_vx), .ball_out_vy(ball_out_vy), .miss_valid(miss_valid),
    .miss_ready(miss_ready), .ball_left(ball_left), .ball_top(ball_top),
    .ball_visible(ball_visible), .paddleX(paddleX), .paddleY(paddleY),
    .opp_score(opp_score)
  );

  always #5 clock = ~clock;

  // Tasks start and end just after a falling edge.
  task automatic tick();
    update_screen = 1'b1;
    @(negedge clock);
    update_screen = 1'b0;
  endtask

  task automatic do_reset(input logic left);
    is_left_player = left;
    reset_L = 1'b0;
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
  endtask

  task automatic send_ball(input logic [9:0] y, input logic [3:0] vx, input logic [3:0] vy);
    ball_in_valid = 1'b1;
    ball_in_y = y;
    ball_in_vx = vx;
    ball_in_vy = vy;
    @(negedge clock);
    ball_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    is_left_player = 1'b1;
    #2 reset_L = 1'b0;
    #1;
    total_cnt++; if (paddleY !== 10'd240) $display("FAIL rst_paddleY got %0d want 240", paddleY); else pass_cnt++;
    total_cnt++; if (ball_left !== 10'd0 || ball_top !== 10'd0) $display("FAIL rst_ball got %0d,%0d want 0,0", ball_left, ball_top); else pass_cnt++;
    total_cnt++; if ({ball_visible, ball_out_valid, miss_valid} !== 3'b000) $display("FAIL rst_flags got %b want 000", {ball_visible, ball_out_valid, miss_valid}); else pass_cnt++;
    total_cnt++; if (opp_score !== 5'd0) $display("FAIL rst_score got %0d want 0", opp_score); else pass_cnt++;
    total_cnt++; if (paddleX !== 10'd60) $display("FAIL rst_paddleX got %0d want 60", paddleX); else pass_cnt++;
    @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
    total_cnt++; if (ball_in_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", ball_in_ready); else pass_cnt++;
  endtask

  task automatic test_paddle();
    joystick_up = 1'b1;
    repeat (5) tick();
    total_cnt++; if (paddleY !== 10'd230) $display("FAIL pad_up got %0d want 230", paddleY); else pass_cnt++;
    joystick_up = 1'b0; joystick_down = 1'b1;
    repeat (5) tick();
    total_cnt++; if (paddleY !== 10'd240) $display("FAIL pad_down got %0d want 240", paddleY); else pass_cnt++;
    joystick_up = 1'b1;
    repeat (10) tick();
    total_cnt++; if (paddleY !== 10'd240) $display("FAIL pad_both got %0d want 240", paddleY); else pass_cnt++;
    joystick_down = 1'b0;
    repeat (120) tick();
    total_cnt++; if (paddleY !== 10'd50) $display("FAIL pad_top_clamp got %0d want 50", paddleY); else pass_cnt++;
    joystick_up = 1'b0; joystick_down = 1'b1;
    repeat (200) tick();
    total_cnt++; if (paddleY !== 10'd429) $display("FAIL pad_bot_clamp got %0d want 429", paddleY); else pass_cnt++;
    joystick_down = 1'b0;
  endtask

  task automatic test_receive();
    do_reset(1'b1);
    send_ball(10'd100, 4'd3, 4'hE);
    total_cnt++; if (ball_left !== 10'd630 || ball_top !== 10'd100) $display("FAIL rx_entry got %0d,%0d want 630,100", ball_left, ball_top); else pass_cnt++;
    total_cnt++; if (ball_visible !== 1'b1 || ball_in_ready !== 1'b0) $display("FAIL rx_flags got vis=%b rdy=%b want 1,0", ball_visible, ball_in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (ball_left !== 10'd627 || ball_top !== 10'd98) $display("FAIL rx_step got %0d,%0d want 627,98", ball_left, ball_top); else pass_cnt++;
  endtask

  task automatic test_bounce_and_send();
    do_reset(1'b1);
    send_ball(10'd235, 4'd7, 4'd0);
    repeat (82) tick();
    total_cnt++; if (ball_left !== 10'd60 || miss_valid !== 1'b0) $display("FAIL bounce_clamp got x=%0d miss=%b want 60,0", ball_left, miss_valid); else pass_cnt++;
    tick();
    total_cnt++; if (ball_left !== 10'd67) $display("FAIL bounce_dir got %0d want 67", ball_left); else pass_cnt++;
    repeat (81) tick();
    total_cnt++; if (ball_out_valid !== 1'b1 || ball_left !== 10'd630) $display("FAIL send_entry got v=%b x=%0d want 1,630", ball_out_valid, ball_left); else pass_cnt++;
    total_cnt++; if (ball_out_y !== 10'd235 || ball_out_vx !== 4'd7 || ball_out_vy !== 4'd0) $display("FAIL send_data got %0d,%0d,%0d want 235,7,0", ball_out_y, ball_out_vx, ball_out_vy); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (ball_out_valid !== 1'b1 || ball_left !== 10'd630 || ball_out_y !== 10'd235) $display("FAIL send_hold%0d got v=%b x=%0d y=%0d want 1,630,235", i, ball_out_valid, ball_left, ball_out_y); else pass_cnt++;
    end
    ball_out_ready = 1'b1;
    @(negedge clock);
    ball_out_ready = 1'b0;
    total_cnt++; if ({ball_out_valid, ball_visible, ball_in_ready} !== 3'b001) $display("FAIL send_done got %b want 001", {ball_out_valid, ball_visible, ball_in_ready}); else pass_cnt++;
  endtask

  task automatic test_miss();
    do_reset(1'b1);
    send_ball(10'd400, 4'd15, 4'd0);
    repeat (41) tick();
    total_cnt++; if (ball_left !== 10'd15 || miss_valid !== 1'b0) $display("FAIL miss_pass got x=%0d miss=%b want 15,0", ball_left, miss_valid); else pass_cnt++;
    tick();
    total_cnt++; if (miss_valid !== 1'b1 || opp_score !== 5'd1) $display("FAIL miss_entry got miss=%b score=%0d want 1,1", miss_valid, opp_score); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++; if (miss_valid !== 1'b1 || ball_left !== 10'd15) $display("FAIL miss_hold%0d got miss=%b x=%0d want 1,15", i, miss_valid, ball_left); else pass_cnt++;
    end
    miss_ready = 1'b1;
    @(negedge clock);
    miss_ready = 1'b0;
    total_cnt++; if (miss_valid !== 1'b0 || opp_score !== 5'd1 || ball_in_ready !== 1'b1) $display("FAIL miss_done got miss=%b score=%0d rdy=%b want 0,1,1", miss_valid, opp_score, ball_in_ready); else pass_cnt++;
  endtask

  task automatic test_vy_saturate();
    do_reset(1'b1);
    send_ball(10'd5, 4'd1, 4'h8);
    tick();
    total_cnt++; if (ball_top !== 10'd0 || ball_out_vy !== 4'd7) $display("FAIL vy_top got y=%0d vy=%0d want 0,7", ball_top, ball_out_vy); else pass_cnt++;
    tick();
    total_cnt++; if (ball_top !== 10'd7) $display("FAIL vy_after got %0d want 7", ball_top); else pass_cnt++;
    joystick_up = 1'b1; joystick_down = 1'b1;
    repeat (10) tick();
    joystick_up = 1'b0; joystick_down = 1'b0;
    total_cnt++; if (paddleY !== 10'd240) $display("FAIL vy_both_joy got %0d want 240", paddleY); else pass_cnt++;
  endtask

  task automatic test_serve();
    do_reset(1'b1);
    serve_start = 1'b1;
    @(negedge clock);
    serve_start = 1'b0;
    total_cnt++; if (ball_left !== 10'd60 || ball_top !== 10'd235 || ball_visible !== 1'b1) $display("FAIL serve_pos got %0d,%0d vis=%b want 60,235,1", ball_left, ball_top, ball_visible); else pass_cnt++;
    joystick_up = 1'b1;
    tick();
    joystick_up = 1'b0;
    @(negedge clock);
    total_cnt++; if (ball_top !== 10'd233) $display("FAIL serve_track got %0d want 233", ball_top); else pass_cnt++;
    arcade_button_pressed = 1'b1;
    @(negedge clock);
    arcade_button_pressed = 1'b0;
    tick();
    total_cnt++; if (ball_left !== 10'd63 || ball_top !== 10'd235) $display("FAIL serve_launch got %0d,%0d want 63,235", ball_left, ball_top); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    do_reset(1'b1);
    serve_start = 1'b1;
    send_ball(10'd50, 4'd2, 4'd0);
    serve_start = 1'b0;
    total_cnt++; if (ball_left !== 10'd630 || ball_in_ready !== 1'b0) $display("FAIL simul_entry got x=%0d rdy=%b want 630,0", ball_left, ball_in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (ball_left !== 10'd628) $display("FAIL simul_step got %0d want 628", ball_left); else pass_cnt++;
  endtask

  task automatic test_right_player();
    do_reset(1'b0);
    total_cnt++; if (paddleX !== 10'd580) $display("FAIL right_paddleX got %0d want 580", paddleX); else pass_cnt++;
    send_ball(10'd235, 4'd10, 4'd0);
    total_cnt++; if (ball_left !== 10'd0) $display("FAIL right_entry got %0d want 0", ball_left); else pass_cnt++;
    repeat (57) tick();
    total_cnt++; if (ball_left !== 10'd570) $display("FAIL right_hit got %0d want 570", ball_left); else pass_cnt++;
    tick();
    total_cnt++; if (ball_left !== 10'd560) $display("FAIL right_dir got %0d want 560", ball_left); else pass_cnt++;
  endtask

  task automatic test_reset_in_send();
    do_reset(1'b1);
    serve_start = 1'b1;
    @(negedge clock);
    serve_start = 1'b0;
    arcade_button_pressed = 1'b1;
    @(negedge clock);
    arcade_button_pressed = 1'b0;
    joystick_up = 1'b1;
    repeat (10) tick();
    joystick_up = 1'b0;
    repeat (179) tick();
    total_cnt++; if (ball_out_valid !== 1'b0 || ball_left !== 10'd627) $display("FAIL rsend_pre got v=%b x=%0d want 0,627", ball_out_valid, ball_left); else pass_cnt++;
    tick();
    total_cnt++; if (ball_out_valid !== 1'b1 || ball_out_y !== 10'd326 || paddleY !== 10'd220) $display("FAIL rsend_send got v=%b y=%0d p=%0d want 1,326,220", ball_out_valid, ball_out_y, paddleY); else pass_cnt++;
    #2 reset_L = 1'b0;
    #1;
    total_cnt++; if ({ball_out_valid, miss_valid, ball_visible} !== 3'b000) $display("FAIL rsend_async got %b want 000", {ball_out_valid, miss_valid, ball_visible}); else pass_cnt++;
    @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
    total_cnt++; if (paddleY !== 10'd240 || ball_in_ready !== 1'b1) $display("FAIL rsend_release got p=%0d rdy=%b want 240,1", paddleY, ball_in_ready); else pass_cnt++;
  endtask

  task automatic test_score_saturate();
    do_reset(1'b1);
    for (int i = 0; i < 32; i++) begin
      send_ball(10'd400, 4'd15, 4'd0);
      repeat (42) tick();
      miss_ready = 1'b1;
      @(negedge clock);
      miss_ready = 1'b0;
      if (i == 30) begin
        total_cnt++; if (opp_score !== 5'd31) $display("FAIL score_31 got %0d want 31", opp_score); else pass_cnt++;
      end
    end
    total_cnt++; if (opp_score !== 5'd31) $display("FAIL score_sat got %0d want 31", opp_score); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_paddle();
    test_receive();
    test_bounce_and_send();
    test_miss();
    test_vy_saturate();
    test_serve();
    test_simultaneous();
    test_right_player();
    test_reset_in_send();
    test_score_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
